// File: rtl/jtcps1_linebuf_pkg.sv
`default_nettype none
// ============================================================================
// jtcps1_linebuf_pkg
// Shared defaults for the CPS1 scroll line buffer: geometry, transparent
// word and the {palette, pen} split of a pixel word.
// Rev 1.0 - initial release
// ============================================================================
package jtcps1_linebuf_pkg;
  localparam int AW = 9;
  localparam int DW = 9;
  localparam logic [DW-1:0] BLANK = 9'h00F;

  localparam int PAL_MSB = 8;
  localparam int PAL_LSB = 4;
  localparam int PEN_MSB = 3;

  function automatic logic [PAL_MSB-PAL_LSB:0] pxl_pal(input logic [DW-1:0] w);
    return w[PAL_MSB:PAL_LSB];
  endfunction

  function automatic logic [PEN_MSB:0] pxl_pen(input logic [DW-1:0] w);
    return w[PEN_MSB:0];
  endfunction
endpackage
`default_nettype wire

// File: rtl/jtcps1_linebuf_bank.sv
`default_nettype none
// ============================================================================
// jtcps1_linebuf_bank
// One line buffer bank: single-port 2^AW x DW synchronous RAM. The port is
// shared between tilemap writes and the read-and-clear access of the read
// pass; a read-and-clear returns the old word and stores BLANK.
// Rev 1.0 - initial release
// ============================================================================
module jtcps1_linebuf_bank
  import jtcps1_linebuf_pkg::*;
#(
  parameter int              AW    = jtcps1_linebuf_pkg::AW,
  parameter int              DW    = jtcps1_linebuf_pkg::DW,
  parameter logic [DW-1:0]   BLANK = jtcps1_linebuf_pkg::BLANK
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          we;

  // Port mux: a read-and-clear owns the port over a tilemap write
  always_comb begin
    addr = wr_addr;
    din  = wr_data;
    we   = wr_en;
    if (clr_en) begin
      addr = clr_addr;
      din  = BLANK;
      we   = 1'b1;
    end
  end

  // Read-first RAM: rd_data gets the word before the clear lands
  always_ff @(posedge clk) begin
    if (we)     mem[addr] <= din;
    if (clr_en) rd_data   <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/jtcps1_scroll_linebuf.sv
`default_nettype none
// ============================================================================
// jtcps1_scroll_linebuf
// Double-buffered scanline buffer between the CPS1 scroll tilemap and the
// colour mixer. One bank captures tilemap writes, the other is streamed out
// at pixel cadence and cleared behind the read. Banks swap on line_start.
// Optional macro JTCPS1_LINEBUF_FLIP_EN adds a 'flip' input that mirrors the
// read address.
// Rev 1.0 - initial release
// ============================================================================
module jtcps1_scroll_linebuf
  import jtcps1_linebuf_pkg::*;
#(
  parameter int            AW    = jtcps1_linebuf_pkg::AW,
  parameter int            DW    = jtcps1_linebuf_pkg::DW,
  parameter logic [DW-1:0] BLANK = jtcps1_linebuf_pkg::BLANK
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          line_start,
  input  logic          tile_done,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_wr,
  input  logic [AW-1:0] hdump,
`ifdef JTCPS1_LINEBUF_FLIP_EN
  input  logic          flip,
`endif
  output logic [DW-1:0] pxl,
  output logic          wr_bank,
  output logic          overrun
);

  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_addr_nx;
  logic          rd_bank;
  logic          stg1;
  logic          stg2;
  logic          busy;
  logic          done_l;
  logic          done_rise;
  logic [DW-1:0] dout [2];

  assign done_rise = tile_done & ~done_l;

  // Read address for the pass starting on this pxl_cen
  always_comb begin
`ifdef JTCPS1_LINEBUF_FLIP_EN
    rd_addr_nx = flip ? ~hdump : hdump;
`else
    rd_addr_nx = hdump;
`endif
  end

  // Bank swap, read pipeline and busy/overrun tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      pxl     <= BLANK;
      overrun <= 1'b0;
      rd_addr <= '0;
      rd_bank <= 1'b0;
      stg1    <= 1'b0;
      stg2    <= 1'b0;
      busy    <= 1'b0;
      done_l  <= 1'b0;
    end else begin
      if (line_start) wr_bank <= ~wr_bank;
      stg1 <= pxl_cen;
      stg2 <= stg1;
      // Bank is latched here so a swap mid-pass still clears the bank read
      if (pxl_cen) begin
        rd_addr <= rd_addr_nx;
        rd_bank <= ~wr_bank;
      end
      // pxl_cen spacing keeps rd_bank stable until this stage
      if (stg2) pxl <= dout[rd_bank];
      done_l  <= tile_done;
      overrun <= line_start & busy & ~done_rise;
      if (line_start)     busy <= 1'b1;
      else if (done_rise) busy <= 1'b0;
    end
  end

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam logic SEL = 1'(b);
      jtcps1_linebuf_bank #(
        .AW    (AW),
        .DW    (DW),
        .BLANK (BLANK)
      ) u_bank (
        .clk      (clk),
        .wr_en    (buf_wr & (wr_bank == SEL)),
        .wr_addr  (buf_addr),
        .wr_data  (buf_data),
        .clr_en   (stg1 & (rd_bank == SEL)),
        .clr_addr (rd_addr),
        .rd_data  (dout[b])
      );
    end
  endgenerate

endmodule
`default_nettype wire
